// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: read-side consumer of the UART byte FIFO. Pops one byte at a
// time and serializes it onto the tx line, LSB first, as an 8N1 frame.
//
// Configuration macro: UART_TX_PARITY_EN
//   undefined - 8N1 frame, (DATA_WIDTH+2)*CLKS_PER_BIT clocks long
//   defined   - 8E1 frame: an even-parity bit is inserted between the last
//               data bit and the stop bit, (DATA_WIDTH+3)*CLKS_PER_BIT clocks
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   tx_en_i       1 = allowed to start new frames
//   fifo_empty_i  FIFO empty flag
//   fifo_rd_en_o  FIFO pop strobe, registered, one-cycle pulse
//   fifo_rdata_i  FIFO data_out, valid the cycle after the pop strobe
//   tx_o          serial line, registered, idles high
//   busy_o        high whenever the FSM is not idle
//   tx_done_o     one-cycle pulse on the last clock of the stop bit
module uart_fifo_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tx_en_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  tx_done_o
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW  = $clog2(DATA_WIDTH + 1);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [BaudW-1:0]      baud_q, baud_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  rd_en_q, rd_en_d;
    logic                  bit_end;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign bit_end = (baud_q == BaudLast);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (tx_en_i && !fifo_empty_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                // FIFO data_out is valid now, one cycle after the pop strobe.
                shift_d = fifo_rdata_i;
                bit_d   = '0;
                baud_d  = '0;
                state_d = StStart;
`ifdef UART_TX_PARITY_EN
                parity_d = ^fifo_rdata_i;
`endif
            end
            StStart: begin
                baud_d = bit_end ? '0 : baud_q + BaudW'(1);
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                baud_d = bit_end ? '0 : baud_q + BaudW'(1);
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                baud_d = bit_end ? '0 : baud_q + BaudW'(1);
                if (bit_end) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                baud_d = bit_end ? '0 : baud_q + BaudW'(1);
                if (bit_end) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Line level follows the next state so tx_o changes on the same edge as the FSM.
        tx_d = 1'b1;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase

        rd_en_d = (state_d == StFetch);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            rd_en_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            rd_en_q  <= rd_en_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_o         = tx_q;
    assign fifo_rd_en_o = rd_en_q;
    assign busy_o       = (state_q != StIdle);
    assign tx_done_o    = (state_q == StStop) && bit_end;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed testbench for uart_fifo_tx with CLKS_PER_BIT=4, DATA_WIDTH=8 and a
// byte FIFO model whose data_out is registered (valid the cycle after a pop).
module tb_uart_fifo_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic [7:0] fifo_rdata = 8'h00;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic [7:0] fifo_q[$];
    int         cyc = 0;
    int         rd_count = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    uart_fifo_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tx_en_i     (tx_en),
        .fifo_empty_i(fifo_empty),
        .fifo_rd_en_o(fifo_rd_en),
        .fifo_rdata_i(fifo_rdata),
        .tx_o        (tx),
        .busy_o      (busy),
        .tx_done_o   (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en === 1'b1) rd_count <= rd_count + 1;
        if (fifo_rd_en === 1'b1 && fifo_q.size() > 0) begin
            fifo_rdata <= fifo_q[0];
            fifo_empty <= (fifo_q.size() == 1);
            fifo_q.delete(0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    function automatic logic exp_tx(input logic [7:0] b, input int k);
        int s;
        s = k / CPB;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
`ifdef UART_TX_PARITY_EN
        if (s == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Bench receiver: called on a negedge; waits for a start bit and samples
    // each bit mid-period. Returns on the last cycle of the stop bit.
    task automatic rx_frame(input int drop_k, output logic [7:0] data, output logic frame_ok,
                            output logic par, output int start_cyc, output int done_k,
                            output logic timeout);
        int n;
        int s;
        n = 0;
        data = 8'h00;
        frame_ok = 1'b1;
        par = 1'b0;
        start_cyc = 0;
        done_k = -1;
        timeout = 1'b0;
        while (tx !== 1'b0) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                timeout = 1'b1;
                return;
            end
        end
        start_cyc = cyc;
        for (int k = 0; k < FRAME; k++) begin
            if (k == drop_k) tx_en = 1'b0;
            if (tx_done === 1'b1 && done_k < 0) done_k = k;
            if (k % CPB == CPB / 2) begin
                s = k / CPB;
                if (s == 0) frame_ok = frame_ok & (tx === 1'b0);
                else if (s <= 8) data[s-1] = tx;
`ifdef UART_TX_PARITY_EN
                else if (s == 9) par = tx;
`endif
                else frame_ok = frame_ok & (tx === 1'b1);
            end
            if (k < FRAME - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
        n_cmp++; if (tx_done !== 1'b0) begin n_bad++; $display("FAIL reset_tx_done got %b want 0", tx_done); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy got %b want 0", busy); end
    endtask

    task automatic test_idle_empty();
        int rd0;
        logic saw_low;
        logic saw_busy;
        rd0 = rd_count;
        saw_low = 1'b0;
        saw_busy = 1'b0;
        tx_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        n_cmp++; if (rd_count !== rd0) begin n_bad++; $display("FAIL empty_rd_pulses got %0d want 0", rd_count - rd0); end
        n_cmp++; if (saw_low !== 1'b0) begin n_bad++; $display("FAIL empty_tx_low got %b want 0", saw_low); end
        n_cmp++; if (saw_busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy got %b want 0", saw_busy); end
    endtask

    task automatic test_single();
        int rd0;
        logic [7:0] b;
        b = 8'h55;
        rd0 = rd_count;
        push(b);
        @(negedge clk);
        n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL single_fetch_rd_en got %b want 1", fifo_rd_en); end
        @(negedge clk);
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL single_load_rd_en got %b want 0", fifo_rd_en); end
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL single_load_tx got %b want 1", tx); end
        @(negedge clk);
        for (int k = 0; k < FRAME; k++) begin
            n_cmp++;
            if (tx !== exp_tx(b, k)) begin
                n_bad++; $display("FAIL single_tx k=%0d got %b want %b", k, tx, exp_tx(b, k));
            end
            n_cmp++;
            if (tx_done !== (k == FRAME - 1)) begin
                n_bad++; $display("FAIL single_tx_done k=%0d got %b want %b", k, tx_done, (k == FRAME - 1));
            end
            @(negedge clk);
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after got %b want 0", busy); end
        n_cmp++; if (tx_done !== 1'b0) begin n_bad++; $display("FAIL single_done_after got %b want 0", tx_done); end
        n_cmp++; if (rd_count - rd0 !== 1) begin n_bad++; $display("FAIL single_rd_pulses got %0d want 1", rd_count - rd0); end
    endtask

    task automatic test_back_to_back();
        int rd0, s1, s2, dk;
        logic [7:0] d1, d2;
        logic ok1, ok2, p, to1, to2;
        rd0 = rd_count;
        push(8'hA5);
        push(8'h3C);
        rx_frame(-1, d1, ok1, p, s1, dk, to1);
        rx_frame(-1, d2, ok2, p, s2, dk, to2);
        n_cmp++; if (to1 !== 1'b0 || to2 !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout got %b%b want 00", to1, to2); end
        n_cmp++; if (d1 !== 8'hA5) begin n_bad++; $display("FAIL b2b_byte0 got %h want a5", d1); end
        n_cmp++; if (d2 !== 8'h3C) begin n_bad++; $display("FAIL b2b_byte1 got %h want 3c", d2); end
        n_cmp++; if ((ok1 & ok2) !== 1'b1) begin n_bad++; $display("FAIL b2b_framing got %b%b want 11", ok1, ok2); end
        n_cmp++; if (s2 - s1 !== FRAME + 3) begin n_bad++; $display("FAIL b2b_gap got %0d want %0d", s2 - s1, FRAME + 3); end
        n_cmp++; if (rd_count - rd0 !== 2) begin n_bad++; $display("FAIL b2b_rd_pulses got %0d want 2", rd_count - rd0); end
        @(negedge clk);
    endtask

    task automatic test_tx_en_drop();
        int rd0, s, dk;
        logic [7:0] d;
        logic ok, p, to;
        logic saw_busy;
        rd0 = rd_count;
        push(8'hFF);
        push(8'h01);
        // Drop tx_en in the middle of data bit 2.
        rx_frame(CPB + 2 * CPB + 1, d, ok, p, s, dk, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL drop_timeout got %b want 0", to); end
        n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("FAIL drop_byte0 got %h want ff", d); end
        n_cmp++; if (dk !== FRAME - 1) begin n_bad++; $display("FAIL drop_done_k got %0d want %0d", dk, FRAME - 1); end
        saw_busy = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        n_cmp++; if (rd_count - rd0 !== 1) begin n_bad++; $display("FAIL drop_rd_held got %0d want 1", rd_count - rd0); end
        n_cmp++; if (saw_busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy_held got %b want 0", saw_busy); end
        tx_en = 1'b1;
        rx_frame(-1, d, ok, p, s, dk, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL drop_resume_timeout got %b want 0", to); end
        n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL drop_byte1 got %h want 01", d); end
        n_cmp++; if (rd_count - rd0 !== 2) begin n_bad++; $display("FAIL drop_rd_total got %0d want 2", rd_count - rd0); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int rd0, n, s, dk;
        logic [7:0] d;
        logic ok, p, to;
        rd0 = rd_count;
        push(8'h0F);
        push(8'hC3);
        n = 0;
        while (tx !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL rstmid_start got %b want 0", tx); end
        repeat (CPB + 4 * CPB + 1) @(negedge clk);
        // Data bit 4 of 0x0F is 0, so the async return to high is visible.
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL rstmid_bit4 got %b want 0", tx); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_rd_en got %b want 0", fifo_rd_en); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx_frame(-1, d, ok, p, s, dk, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rstmid_timeout got %b want 0", to); end
        n_cmp++; if (d !== 8'hC3) begin n_bad++; $display("FAIL rstmid_next_byte got %h want c3", d); end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rstmid_framing got %b want 1", ok); end
        n_cmp++; if (rd_count - rd0 !== 2) begin n_bad++; $display("FAIL rstmid_rd_pulses got %0d want 2", rd_count - rd0); end
        @(negedge clk);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int s, dk;
        logic [7:0] d;
        logic ok, p, to;
        push(8'h07);
        rx_frame(-1, d, ok, p, s, dk, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL parity_timeout got %b want 0", to); end
        n_cmp++; if (d !== 8'h07) begin n_bad++; $display("FAIL parity_byte got %h want 07", d); end
        n_cmp++; if (p !== 1'b1) begin n_bad++; $display("FAIL parity_bit got %b want 1", p); end
        n_cmp++; if (dk !== 43) begin n_bad++; $display("FAIL parity_done_k got %0d want 43", dk); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_idle_empty();
        test_single();
        test_back_to_back();
        test_tx_en_drop();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
